mem_port_arbiter: RTL and testbench

Arbiter that shares one single-ported, fixed one-cycle-latency SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester of the pipelined CPU. Each side gets a req/addr_ok/data_ok handshake with a per-requester one-entry response skid buffer. Data requests win by default; an optional starvation guard protects fetch. It sits between the fetch/memory pipeline stages and the unified memory port.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency memory port between fetch and data requesters.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT lost arbitration cycles.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    input  logic                inst_rready,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    input  logic                data_rready,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    owner_t              owner, owner_nx;
    logic                owner_wr, owner_wr_nx;
    logic                skid_vi, skid_vd;
    logic [DATA_W-1:0]   skid_di, skid_dd;
    logic                inst_elig, data_elig, grant_i, grant_d, force_i;
    logic [DATA_W-1:0]   inst_resp, data_resp;

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be >= 1");
    end

    // A requester whose previous response would stall (rready low) may not issue again.
    assign inst_elig = inst_req & ~skid_vi & ~(owner == OWN_INST & ~inst_rready);
    assign data_elig = data_req & ~skid_vd & ~(owner == OWN_DATA & ~data_rready);
    assign grant_d   = data_elig & ~force_i;
    assign grant_i   = inst_elig & (~data_elig | force_i);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] cnt;

    assign force_i = inst_elig & (cnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (!inst_req || grant_i)
            cnt <= '0;
        else if (inst_elig && grant_d && cnt != CNT_W'(STARVE_LIMIT))
            cnt <= cnt + 1'b1;
    end
`else
    assign force_i = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner    <= OWN_NONE;
            owner_wr <= 1'b0;
        end else begin
            owner    <= owner_nx;
            owner_wr <= owner_wr_nx;
        end
    end

    always_comb begin
        owner_nx    = grant_d ? OWN_DATA : grant_i ? OWN_INST : OWN_NONE;
        owner_wr_nx = grant_d & data_wr;
    end

    // Fetch responses are never stores; data-side store responses read as 0.
    assign inst_resp = skid_vi ? skid_di : (owner == OWN_INST) ? mem_rdata : '0;
    assign data_resp = skid_vd ? skid_dd : (owner == OWN_DATA && !owner_wr) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_vi <= 1'b0;
            skid_di <= '0;
            skid_vd <= 1'b0;
            skid_dd <= '0;
        end else begin
            if (owner == OWN_INST && !skid_vi && !inst_rready) begin
                skid_vi <= 1'b1;
                skid_di <= inst_resp;
            end else if (skid_vi && inst_rready) begin
                skid_vi <= 1'b0;
            end
            if (owner == OWN_DATA && !skid_vd && !data_rready) begin
                skid_vd <= 1'b1;
                skid_dd <= data_resp;
            end else if (skid_vd && data_rready) begin
                skid_vd <= 1'b0;
            end
        end
    end

    always_comb begin
        inst_addr_ok = resetn & grant_i;
        data_addr_ok = resetn & grant_d;
        mem_en       = resetn & (grant_i | grant_d);
        mem_we       = (resetn && grant_d && data_wr) ? data_wstrb : '0;
        mem_addr     = !resetn ? '0 : grant_d ? data_addr : grant_i ? inst_addr : '0;
        mem_wdata    = resetn ? data_wdata : '0;
        inst_data_ok = resetn & (skid_vi | (owner == OWN_INST));
        data_data_ok = resetn & (skid_vd | (owner == OWN_DATA));
        inst_rdata   = resetn ? inst_resp : '0;
        data_rdata   = resetn ? data_resp : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, skid buffering, stores, reset and throughput.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic inst_req, inst_addr_ok, inst_rready, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic data_req, data_wr, data_addr_ok, data_rready, data_data_ok;
  logic [3:0] data_wstrb, mem_we;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int checks = 0;
  int fails = 0;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_rready(inst_rready), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rready(data_rready), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask
  initial begin
    resetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; inst_rready = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF;
    data_addr = 32'h0000_1000; data_wdata = 32'h1234_5678; data_rready = 1'b1;
    mem_rdata = 32'h9999_9999;
    #3;
    chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("rst_data_addr_ok", data_addr_ok, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 4'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk("rst_data_data_ok", data_data_ok, 1'b0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    cyc(); cyc();
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    #2 resetn = 1'b1;
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    data_req = 1'b1; data_addr = 32'h0000_1000;
    #2;
    chk("cf_data_addr_ok", data_addr_ok, 1'b1);
    chk("cf_inst_addr_ok0", inst_addr_ok, 1'b0);
    chk("cf_mem_addr_d", mem_addr, 32'h0000_1000);
    chk("cf_mem_we_load", mem_we, 4'h0);
    cyc();
    data_req = 1'b0; mem_rdata = 32'hAAAA_0001;
    #2;
    chk("cf_inst_addr_ok1", inst_addr_ok, 1'b1);
    chk("cf_mem_addr_i", mem_addr, 32'h1C00_0000);
    chk("cf_data_data_ok", data_data_ok, 1'b1);
    chk("cf_data_rdata", data_rdata, 32'hAAAA_0001);
    chk("cf_inst_data_ok0", inst_data_ok, 1'b0);
    cyc();
    inst_req = 1'b0; mem_rdata = 32'hBBBB_0002;
    #2;
    chk("cf_inst_data_ok", inst_data_ok, 1'b1);
    chk("cf_inst_rdata", inst_rdata, 32'hBBBB_0002);
    chk("cf_idle_mem_en", mem_en, 1'b0);
    chk("cf_data_data_ok0", data_data_ok, 1'b0);
    cyc();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h10; data_wdata = 32'hDEAD_BEEF;
    #2;
    chk("st_addr_ok", data_addr_ok, 1'b1);
    chk("st_mem_we", mem_we, 4'b0011);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_addr", mem_addr, 32'h10);
    cyc();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; mem_rdata = 32'h5555_5555;
    #2;
    chk("st_data_ok", data_data_ok, 1'b1);
    chk("st_rdata_zero", data_rdata, 32'h0);
    chk("st_mem_we_idle", mem_we, 4'h0);
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1C00_0040;
    #2;
    chk("bp_grant", inst_addr_ok, 1'b1);
    cyc();
    inst_req = 1'b0; inst_rready = 1'b0; mem_rdata = 32'h1234_5678;
    #2;
    chk("bp_direct_ok", inst_data_ok, 1'b1);
    chk("bp_direct_rdata", inst_rdata, 32'h1234_5678);
    for (int i = 0; i < 2; i++) begin
      cyc();
      inst_req = 1'b1; inst_addr = 32'h1C00_0044; mem_rdata = 32'hFFFF_FFFF;
      #2;
      chk("bp_held_addr_ok", inst_addr_ok, 1'b0);
      chk("bp_held_data_ok", inst_data_ok, 1'b1);
      chk("bp_held_rdata", inst_rdata, 32'h1234_5678);
      chk("bp_held_mem_en", mem_en, 1'b0);
    end
    cyc();
    inst_rready = 1'b1; data_req = 1'b1; data_addr = 32'h2000;
    #2;
    chk("bp_pop_data_ok", inst_data_ok, 1'b1);
    chk("bp_pop_rdata", inst_rdata, 32'h1234_5678);
    chk("bp_pop_inst_addr_ok", inst_addr_ok, 1'b0);
    chk("bp_pop_data_grant", data_addr_ok, 1'b1);
    cyc();
    data_req = 1'b0; mem_rdata = 32'h0000_CAFE;
    #2;
    chk("bp_after_inst_grant", inst_addr_ok, 1'b1);
    chk("bp_after_inst_data_ok", inst_data_ok, 1'b0);
    chk("bp_after_data_ok", data_data_ok, 1'b1);
    chk("bp_after_data_rdata", data_rdata, 32'h0000_CAFE);
    cyc();
    inst_req = 1'b0; mem_rdata = 32'h0BAD_0044;
    #2;
    chk("bp_new_resp", inst_rdata, 32'h0BAD_0044);
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    #2;
    chk("rm_grant", inst_addr_ok, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rm_addr_ok_gated", inst_addr_ok, 1'b0);
    chk("rm_mem_en_gated", mem_en, 1'b0);
    chk("rm_mem_addr_gated", mem_addr, 32'h0);
    cyc();
    inst_req = 1'b0; mem_rdata = 32'h7777_7777;
    #2;
    chk("rm_no_data_ok", inst_data_ok, 1'b0);
    chk("rm_rdata_zero", inst_rdata, 32'h0);
    resetn = 1'b1;
    #1;
    chk("rm_dropped", inst_data_ok, 1'b0);
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1C00_0100;
    #2;
    chk("rm_post_grant", inst_addr_ok, 1'b1);
    chk("rm_post_mem_addr", mem_addr, 32'h1C00_0100);
    cyc();
    inst_req = 1'b0; mem_rdata = 32'h0000_600D;
    #2;
    chk("rm_post_data_ok", inst_data_ok, 1'b1);
    chk("rm_post_rdata", inst_rdata, 32'h0000_600D);
    cyc();
    #2;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      inst_req = 1'b1; inst_addr = 32'h1C00_0200;
      data_req = 1'b1; data_addr = 32'h4000;
      #2;
`ifdef ARB_STARVE_GUARD_EN
      chk("sv_inst_grant", inst_addr_ok, (i == 5));
      chk("sv_data_grant", data_addr_ok, (i != 5));
`else
      chk("sv_inst_grant", inst_addr_ok, 1'b0);
      chk("sv_data_grant", data_addr_ok, 1'b1);
`endif
    end
    cyc();
    inst_req = 1'b0; data_req = 1'b0;
    #2;
    cyc();
    #2;
    for (int k = 0; k <= 8; k++) begin
      cyc();
      inst_req = (k < 8) && (k % 2 == 0);
      data_req = (k < 8) && (k % 2 == 1);
      inst_addr = 32'h1C00_0000 + 32'(4 * k);
      data_addr = 32'h3000 + 32'(4 * k);
      mem_rdata = 32'hF000_0000 | 32'(k - 1);
      #2;
      if (k < 8) begin
        chk("tp_accept", (k % 2 == 0) ? inst_addr_ok : data_addr_ok, 1'b1);
        chk("tp_mem_addr", mem_addr, (k % 2 == 0) ? 32'h1C00_0000 + 32'(4 * k) : 32'h3000 + 32'(4 * k));
      end
      if (k > 0) begin
        chk("tp_resp_ok", ((k - 1) % 2 == 0) ? inst_data_ok : data_data_ok, 1'b1);
        chk("tp_resp_other", ((k - 1) % 2 == 0) ? data_data_ok : inst_data_ok, 1'b0);
        chk("tp_resp_data", ((k - 1) % 2 == 0) ? inst_rdata : data_rdata, 32'hF000_0000 | 32'(k - 1));
      end
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
